// File: rtl/mult_booth_r4_pkg.sv
// mult_booth_r4_pkg: shared multdiv constants, state encoding, Booth codes and the lookahead add
package mult_booth_r4_pkg;
    localparam int WIDTH = 32;
    localparam int ACC_W = 34;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] SEL_ZERO  = 3'b000;
    localparam logic [2:0] SEL_PM_A  = 3'b001;
    localparam logic [2:0] SEL_PM_B  = 3'b010;
    localparam logic [2:0] SEL_P2M   = 3'b011;
    localparam logic [2:0] SEL_N2M   = 3'b100;
    localparam logic [2:0] SEL_NM_A  = 3'b101;
    localparam logic [2:0] SEL_NM_B  = 3'b110;
    localparam logic [2:0] SEL_ZERO2 = 3'b111;

    // Generate/propagate carry chain; the final carry-out is dropped (sum is modulo 2^ACC_W)
    function automatic logic [ACC_W-1:0] add_cla(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                                 input logic cin);
        logic [ACC_W-1:0] g, p;
        logic [ACC_W:0] c;
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < ACC_W; i++) c[i+1] = g[i] | (p[i] & c[i]);
        return p ^ c[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/booth_r4_sel.sv
// booth_r4_sel: radix-4 Booth addend select; negatives are the inverted operand with cin = 1
module booth_r4_sel
    import mult_booth_r4_pkg::*;
(
    input  logic [2:0]       sel,
    input  logic [ACC_W-1:0] m,
    output logic [ACC_W-1:0] addend,
    output logic             cin
);
    logic [ACC_W-1:0] m2;

    assign m2 = m << 1;

    always_comb begin
        addend = '0;
        cin    = 1'b0;
        case (sel)
            SEL_PM_A, SEL_PM_B: addend = m;
            SEL_P2M:            addend = m2;
            SEL_N2M:            begin addend = ~m2; cin = 1'b1; end
            SEL_NM_A, SEL_NM_B: begin addend = ~m;  cin = 1'b1; end
            default:            addend = '0;
        endcase
    end
endmodule

// File: rtl/mult_booth_r4.sv
// mult_booth_r4: sequential 32x32 signed radix-4 Booth multiplier, 17-cycle latency
module mult_booth_r4
    import mult_booth_r4_pkg::*;
#(
    parameter int ITER = WIDTH / 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t state;
    logic [ACC_W-1:0] m, acc, addend, sum;
    logic [WIDTH-1:0] q;
    logic q_m1, cin;
    logic [3:0] cnt;
    logic [ACC_W+WIDTH:0] shifted;

    booth_r4_sel u_sel (.sel({q[1:0], q_m1}), .m(m), .addend(addend), .cin(cin));

    assign sum     = add_cla(acc, addend, cin);
    assign shifted = $signed({sum, q, q_m1}) >>> 2;
    assign busy    = state == RUN;

    // Outputs are captured on the final RUN edge so they are valid during the DONE cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            m              <= '0;
            acc            <= '0;
            q              <= '0;
            q_m1           <= 1'b0;
            cnt            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_MULT) begin
                m     <= {{(ACC_W-WIDTH){data_operandA[WIDTH-1]}}, data_operandA};
                acc   <= '0;
                q     <= data_operandB;
                q_m1  <= 1'b0;
                cnt   <= '0;
                state <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        {acc, q, q_m1} <= shifted;
                        cnt            <= cnt + 4'd1;
                        if (cnt == 4'(ITER - 1)) begin
                            state          <= DONE;
                            data_result    <= shifted[WIDTH:1];
                            data_exception <= shifted[2*WIDTH:WIDTH+1] != {WIDTH{shifted[WIDTH]}};
                            data_resultRDY <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
